truth_table_sweeper: RTL and testbench
======================================

Name: truth_table_sweeper

Overview:
- Synthesizable stimulus-and-capture engine for small combinational blocks under test.
- On a start pulse, drives every input combination 0..2^N_IN-1 onto the DUT inputs, holding each for a fixed number of cycles.
- Samples the DUT's single-bit output at the end of each step and assembles the full truth table.
- Sits beside any combinational DUT on an FPGA board, in place of a simulation-only bench.

Parameters:
- N_IN, 3: DUT input width; the table width is 2^N_IN.
- HOLD_CYCLES, 4: clock cycles each input vector is held. A value of 0 is treated as 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- start  input  1  begin a sweep; sampled each cycle
- f_in  input  1  DUT output being captured
- expected  input  2^N_IN  golden truth table; bit i is the expected F for input i
- vec  output  N_IN  drives DUT inputs; MSB maps to x (e.g. {x,y,z} = vec)
- tt  output  2^N_IN  captured truth table; bit i is F sampled for input i
- busy  output  1  sweep in progress
- done  output  1  sweep complete; level signal
- pass  output  1  captured table equals expected (see Optional Feature)
- mismatch  output  2^N_IN  captured XOR expected (see Optional Feature)

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; vec=0, tt=0, busy=0, done=0, pass=0, mismatch=0; hold counter=0.
- States: IDLE, DRIVE, DONE.
- IDLE/DONE + start=1: next edge enters DRIVE. Sets busy=1, done=0, vec=0, hold counter=HOLD_CYCLES-1. Clears tt, pass and mismatch to 0.
- DRIVE, counter>0: decrement the counter; vec is held.
- DRIVE, counter==0: on this edge, tt[vec] <= f_in.
  - If vec != 2^N_IN-1: vec increments and the counter reloads to HOLD_CYCLES-1.
  - Else: state=DONE, busy=0, done=1. vec holds the last value; pass/mismatch update on this same edge.
- Each vector is driven for exactly HOLD_CYCLES cycles. busy is high for exactly 2^N_IN*HOLD_CYCLES cycles. done rises on the edge that samples the last entry.
- start while busy: ignored; there is no restart mid-sweep.
- DONE: tt, done, pass and mismatch are held until the next start or reset. start in DONE behaves as in IDLE.
- Reset mid-sweep wins over everything: all outputs return to reset values on that edge, and the partial table is discarded.
- f_in is sampled only at the last hold cycle; glitches earlier in the step are ignored.
- vec wrap: vec never wraps; the sweep ends at 2^N_IN-1.

Optional Feature:
- Macro TRUTH_TABLE_CHECK_EN.
- Defined: on the edge that enters DONE, mismatch <= {f_in sample merged into tt} XOR expected, and pass <= (mismatch == 0). Both are computed from the final table, including the last sample. Both are held in DONE and cleared on start.
- Undefined: expected is ignored; pass and mismatch are constant 0. The ports remain present.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then start=0 for 10 cycles -> vec=0, tt=0x00, busy=0, done=0 throughout.
- XOR sweep, default params: f_in = ^vec, start pulse -> vec steps 0..7 every 4 cycles; busy high for 32 cycles; done=1 with tt=0x96. With TRUTH_TABLE_CHECK_EN and expected=0x96: pass=1, mismatch=0x00.
- Mismatch detection: f_in = &vec, expected=0x80 except bit 3 flipped (expected=0x88) -> tt=0x80; with the macro, mismatch=0x08 and pass=0.
- Start during busy: a second start pulse at cycle 10 of the sweep -> no effect; done still arrives at cycle 32 and tt is unchanged from a clean sweep.
- Reset mid-sweep: rst_n=0 at cycle 15 -> the next edge gives vec=0, tt=0x00, busy=0, done=0. A subsequent start runs a full 32-cycle sweep.
- HOLD_CYCLES=1, N_IN=2, f_in = vec[1] -> vec = 0,1,2,3 on consecutive cycles; busy for 4 cycles; tt=0xC; restart from DONE clears tt before refilling.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: sweeps every input combination of a small combinational
// block, holds each vector for HOLD_CYCLES clocks, and captures the block's
// single-bit output into a truth table.
// Optional golden-table compare is enabled by defining TRUTH_TABLE_CHECK_EN;
// without it, pass and mismatch are tied to 0 and expected is ignored.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; outputs at reset values
// DRIVE | driving vec, counting down the hold timer, sampling f_in
// DONE  | sweep complete; tt/done/pass/mismatch held until start/reset
module truth_table_sweeper #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   f_in,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic [N_IN-1:0]        vec,
    output logic [(1<<N_IN)-1:0]   tt,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   mismatch
);

    localparam int N_VEC    = 1 << N_IN;
    // A hold of zero would never sample, so it is promoted to one cycle.
    localparam int HOLD_EFF = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam int CW       = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;
    localparam logic [CW-1:0]   RELOAD   = CW'(HOLD_EFF - 1);
    localparam logic [N_IN-1:0] VEC_LAST = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [CW-1:0]       hold_cnt, hold_cnt_d;
    logic [N_IN-1:0]     vec_d;
    logic [N_VEC-1:0]    tt_d;
    logic [N_VEC-1:0]    tt_sampled;
    logic                busy_d, done_d;
    logic                launch, finish;

    // Current table with this step's f_in sample merged in at index vec.
    always_comb begin
        tt_sampled      = tt;
        tt_sampled[vec] = f_in;
    end

    // Next-state and registered-output logic for the sweep FSM.
    always_comb begin
        state_d    = state;
        hold_cnt_d = hold_cnt;
        vec_d      = vec;
        tt_d       = tt;
        busy_d     = busy;
        done_d     = done;
        launch     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    launch     = 1'b1;
                    state_d    = DRIVE;
                    hold_cnt_d = RELOAD;
                    vec_d      = '0;
                    tt_d       = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            DRIVE: begin
                // start is deliberately ignored here: no mid-sweep restart.
                if (hold_cnt != '0) begin
                    hold_cnt_d = hold_cnt - 1'b1;
                end else begin
                    tt_d = tt_sampled;
                    if (vec != VEC_LAST) begin
                        vec_d      = vec + 1'b1;
                        hold_cnt_d = RELOAD;
                    end else begin
                        finish  = 1'b1;
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_cnt <= '0;
            vec      <= '0;
            tt       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_d;
            hold_cnt <= hold_cnt_d;
            vec      <= vec_d;
            tt       <= tt_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

`ifdef TRUTH_TABLE_CHECK_EN
    logic [N_VEC-1:0] mismatch_d;
    logic             pass_d;

    // Compare result: computed from the final table (last sample included).
    always_comb begin
        mismatch_d = mismatch;
        pass_d     = pass;
        if (launch) begin
            mismatch_d = '0;
            pass_d     = 1'b0;
        end else if (finish) begin
            mismatch_d = tt_sampled ^ expected;
            pass_d     = ((tt_sampled ^ expected) == '0);
        end
    end

    // Compare result registers, held through DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mismatch <= '0;
            pass     <= 1'b0;
        end else begin
            mismatch <= mismatch_d;
            pass     <= pass_d;
        end
    end
`else
    logic unused_check;
    assign unused_check = ^{expected, launch, finish};
    assign mismatch     = '0;
    assign pass         = 1'b0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: default instance (N_IN=3,
// HOLD_CYCLES=4) plus a small instance (N_IN=2, HOLD_CYCLES=1).
module tb_truth_table_sweeper;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       f_in;
    logic [7:0] expected;
    logic [2:0] vec;
    logic [7:0] tt;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] mismatch;

    logic       start2;
    logic       f_in2;
    logic [3:0] expected2;
    logic [1:0] vec2;
    logic [3:0] tt2;
    logic       busy2;
    logic       done2;
    logic       pass2;
    logic [3:0] mismatch2;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] tt;
        logic       pass;
        logic [7:0] mm;
    } exp_t;
    exp_t sb_q[$];

    truth_table_sweeper #(.N_IN(3), .HOLD_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .f_in(f_in),
        .expected(expected), .vec(vec), .tt(tt), .busy(busy),
        .done(done), .pass(pass), .mismatch(mismatch)
    );

    truth_table_sweeper #(.N_IN(2), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .f_in(f_in2),
        .expected(expected2), .vec(vec2), .tt(tt2), .busy(busy2),
        .done(done2), .pass(pass2), .mismatch(mismatch2)
    );

    // Small DUT stand-in for the second instance: F = x (vec MSB).
    assign f_in2 = vec2[1];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic fn(input int func, input int idx);
        logic [2:0] v;
        v = idx[2:0];
        if (func == 0) return ^v;
        return &v;
    endfunction

    function automatic exp_t model(input int func, input logic [7:0] gold);
        exp_t e;
        e.tt = '0;
        for (int i = 0; i < 8; i++) e.tt[i] = fn(func, i);
`ifdef TRUTH_TABLE_CHECK_EN
        e.mm   = e.tt ^ gold;
        e.pass = (e.mm == 8'h00);
`else
        e.mm   = 8'h00;
        e.pass = 1'b0;
`endif
        return e;
    endfunction

    // Full sweep on the default instance. poke: cycle index at which a stray
    // start is pulsed (-1 for none). glitch: toggle f_in on non-sampling cycles.
    task automatic sweep(input string name, input int func, input logic [7:0] gold,
                         input int poke, input bit glitch);
        int   k;
        exp_t e;
        expected = gold;
        sb_q.push_back(model(func, gold));
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (tt !== 8'h00 || done !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_launch: tt=%h done=%b busy=%b, required tt=00 done=0 busy=1",
                     name, tt, done, busy);
        end
        k = 0;
        while (busy === 1'b1 && k < 200) begin
            checks++;
            if (vec !== 3'(k / 4)) begin
                errors++;
                $display("FAIL %s_vec: cycle %0d vec=%0d, required %0d", name, k, vec, k / 4);
            end
            f_in  = fn(func, k / 4) ^ (glitch && (k % 4) != 3);
            start = (k == poke);
            k++;
            tick();
        end
        start = 1'b0;
        checks++;
        if (k != 32) begin
            errors++;
            $display("FAIL %s_busy_len: busy cycles=%0d, required 32", name, k);
        end
        checks++;
        if (done !== 1'b1 || vec !== 3'd7) begin
            errors++;
            $display("FAIL %s_done: done=%b vec=%0d, required done=1 vec=7", name, done, vec);
        end
        e = sb_q.pop_front();
        checks++;
        if (tt !== e.tt || pass !== e.pass || mismatch !== e.mm) begin
            errors++;
            $display("FAIL %s_result: tt=%h pass=%b mm=%h, required tt=%h pass=%b mm=%h",
                     name, tt, pass, mismatch, e.tt, e.pass, e.mm);
        end
        f_in = ~f_in;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (tt !== e.tt || done !== 1'b1 || busy !== 1'b0 || mismatch !== e.mm) begin
                errors++;
                $display("FAIL %s_hold: tt=%h done=%b busy=%b mm=%h, required tt=%h done=1 busy=0 mm=%h",
                         name, tt, done, busy, mismatch, e.tt, e.mm);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (vec !== 3'd0 || tt !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
                pass !== 1'b0 || mismatch !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle: cycle %0d vec=%0d tt=%h busy=%b done=%b pass=%b mm=%h, required all 0",
                         i, vec, tt, busy, done, pass, mismatch);
            end
            tick();
        end
    endtask

    task automatic test_xor_sweep();
        sweep("xor", 0, 8'h96, -1, 1'b0);
    endtask

    task automatic test_mismatch();
        sweep("and_mm", 1, 8'h88, -1, 1'b0);
    endtask

    task automatic test_glitch();
        sweep("glitch", 0, 8'h96, -1, 1'b1);
    endtask

    task automatic test_start_during_busy();
        sweep("busy_start", 0, 8'h96, 10, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        expected = 8'h96;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 15; k++) begin
            f_in = fn(0, k / 4);
            tick();
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (vec !== 3'd0 || tt !== 8'h00 || busy !== 1'b0 || done !== 1'b0 ||
            pass !== 1'b0 || mismatch !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset: vec=%0d tt=%h busy=%b done=%b pass=%b mm=%h, required all 0",
                     vec, tt, busy, done, pass, mismatch);
        end
        rst_n = 1'b1;
        tick();
        sweep("after_reset", 0, 8'h96, -1, 1'b0);
    endtask

    task automatic test_small_config();
        int   k;
        exp_t e;
        for (int run = 0; run < 2; run++) begin
            e.tt   = 8'h0C;
`ifdef TRUTH_TABLE_CHECK_EN
            e.pass = 1'b1;
`else
            e.pass = 1'b0;
`endif
            e.mm   = 8'h00;
            sb_q.push_back(e);
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            checks++;
            if (tt2 !== 4'h0 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL small_launch: run %0d tt=%h done=%b, required tt=0 done=0",
                         run, tt2, done2);
            end
            k = 0;
            while (busy2 === 1'b1 && k < 20) begin
                checks++;
                if (vec2 !== 2'(k)) begin
                    errors++;
                    $display("FAIL small_vec: cycle %0d vec=%0d, required %0d", k, vec2, k);
                end
                k++;
                tick();
            end
            checks++;
            if (k != 4) begin
                errors++;
                $display("FAIL small_busy_len: busy cycles=%0d, required 4", k);
            end
            e = sb_q.pop_front();
            checks++;
            if (done2 !== 1'b1 || {4'h0, tt2} !== e.tt || pass2 !== e.pass ||
                {4'h0, mismatch2} !== e.mm) begin
                errors++;
                $display("FAIL small_result: done=%b tt=%h pass=%b mm=%h, required done=1 tt=%h pass=%b mm=%h",
                         done2, tt2, pass2, mismatch2, e.tt[3:0], e.pass, e.mm[3:0]);
            end
            tick();
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        f_in      = 1'b0;
        expected  = 8'h00;
        start2    = 1'b0;
        expected2 = 4'hC;
        test_reset();
        test_xor_sweep();
        test_mismatch();
        test_glitch();
        test_start_during_busy();
        test_reset_mid_sweep();
        test_small_config();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
